vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz raster timing from the 100 MHz board clock.
// A clk divider produces a one-clk pixel_tick; the column/line counters and
// the registered output stage (sync + colour) all advance on pixel_tick
// edges, so hSync, vSync and vga_r/g/b carry one pixel of latency relative
// to hCount/vCount and stay mutually aligned.
// frame_tick is high during the pixel_tick cycle at (H_TOTAL-1, V_TOTAL-1);
// the counters wrap to (0,0) on the edge that ends that cycle.
// Optional build macro VGA_TEST_PATTERN_EN: ignore rgb_in and show eight
// 80-pixel-wide vertical colour bars across the visible window.
module vga_timing_gen #(
  parameter int CLK_DIV      = 4,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC       = 96,
  parameter int H_DISP_START = 144,
  parameter int H_DISP_END   = 783,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC       = 2,
  parameter int V_DISP_START = 35,
  parameter int V_DISP_END   = 514
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pixel_tick,
  output logic        frame_tick,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0] H_DS     = 10'(H_DISP_START);
  localparam logic [9:0] H_DE     = 10'(H_DISP_END);
  localparam logic [9:0] V_DS     = 10'(V_DISP_START);
  localparam logic [9:0] V_DE     = 10'(V_DISP_END);

  logic [DIV_W-1:0] div_cnt;
  logic             div_last;
  logic             at_frame_end;
  logic [11:0]      pix_color;
  logic [11:0]      vga_rgb;

  assign div_last     = (div_cnt == DIV_LAST);
  assign at_frame_end = (hCount == H_LAST) && (vCount == V_LAST);

  // Clock divider: pixel_tick is high for the clk following div_cnt==CLK_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      pixel_tick <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      div_cnt    <= div_last ? '0 : div_cnt + 1'b1;
      pixel_tick <= div_last;
      frame_tick <= div_last && at_frame_end;
    end
  end

  // Raster counters: advance one pixel on every pixel_tick edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hCount <= '0;
      vCount <= '0;
    end else if (pixel_tick) begin
      if (hCount == H_LAST) begin
        hCount <= '0;
        vCount <= (vCount == V_LAST) ? '0 : vCount + 1'b1;
      end else begin
        hCount <= hCount + 1'b1;
      end
    end
  end

  // Visible-window decode from the registered counters.
  always_comb begin
    bright = (hCount >= H_DS) && (hCount <= H_DE) &&
             (vCount >= V_DS) && (vCount <= V_DE);
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] h_off;
  logic [2:0] bar;

  // Colour-bar source: bar index is the 80-pixel column band inside the window.
  always_comb begin
    h_off = hCount - H_DS;
    bar   = 3'(h_off / 10'd80);
    case (bar)
      3'd0:    pix_color = 12'hFFF;
      3'd1:    pix_color = 12'hFF0;
      3'd2:    pix_color = 12'h0FF;
      3'd3:    pix_color = 12'h0F0;
      3'd4:    pix_color = 12'hF0F;
      3'd5:    pix_color = 12'hF00;
      3'd6:    pix_color = 12'h00F;
      default: pix_color = 12'h000;
    endcase
  end
`else
  // Colour source: graphics logic drives the pixel colour directly.
  always_comb begin
    pix_color = rgb_in;
  end
`endif

  // Output stage: sample the pre-update pixel so colour and syncs share one pixel of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_rgb <= '0;
      hSync   <= 1'b1;
      vSync   <= 1'b1;
    end else if (pixel_tick) begin
      vga_rgb <= bright ? pix_color : 12'h000;
      hSync   <= ~(hCount < H_SYNC_W);
      vSync   <= ~(vCount < V_SYNC_W);
    end
  end

  assign vga_r = vga_rgb[11:8];
  assign vga_g = vga_rgb[7:4];
  assign vga_b = vga_rgb[3:0];

endmodule
